acc_resp_reorder: RTL and testbench

- Sits directly downstream of the accelerator dispatcher, between its request/response port and an accelerator core that completes instructions out of order.
- Accepts non-speculative requests in order and allocates a reorder slot for each; the slot index is the tag forwarded to the core.
- Returns results to the dispatcher strictly in issue order.
- Generates the load/store bookkeeping the dispatcher consumes: store_pending, load_complete, store_complete.

---
 rtl/acc_resp_reorder.sv | 175 +++++++++++++++++
 tb/tb_acc_resp_reorder.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_resp_reorder.sv
// Reorder buffer that returns out-of-order accelerator core completions to the dispatcher in issue order.
// Optional feature macro ACC_RESP_BYPASS_EN: zero-latency response when the head slot completes.
module acc_resp_reorder #(
    parameter int unsigned  NrSlots     = 4,
    parameter int unsigned  XLEN        = 64,
    parameter int unsigned  TransIdBits = 3,
    parameter logic [6:0]   LoadOpcode  = 7'b0000111,
    parameter logic [6:0]   StoreOpcode = 7'b0100111,
    localparam int unsigned TagBits     = $clog2(NrSlots)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [31:0]            req_insn_i,
    input  logic [XLEN-1:0]        req_rs1_i,
    input  logic [XLEN-1:0]        req_rs2_i,
    input  logic [TransIdBits-1:0] req_trans_id_i,
    output logic                   core_req_valid_o,
    input  logic                   core_req_ready_i,
    output logic [31:0]            core_insn_o,
    output logic [XLEN-1:0]        core_rs1_o,
    output logic [XLEN-1:0]        core_rs2_o,
    output logic [TagBits-1:0]     core_tag_o,
    input  logic                   core_resp_valid_i,
    input  logic [TagBits-1:0]     core_resp_tag_i,
    input  logic [XLEN-1:0]        core_resp_result_i,
    input  logic                   core_resp_error_i,
    output logic                   resp_valid_o,
    input  logic                   resp_ready_i,
    output logic [TransIdBits-1:0] resp_trans_id_o,
    output logic [XLEN-1:0]        resp_result_o,
    output logic                   resp_error_o,
    output logic                   load_complete_o,
    output logic                   store_complete_o,
    output logic                   store_pending_o,
    output logic                   idle_o
);

    typedef enum logic [1:0] {SLOT_FREE, SLOT_ISSUED, SLOT_DONE} slot_state_e;
    typedef logic [TagBits-1:0] tag_t;
    typedef logic [TagBits:0]   cnt_t;

    localparam cnt_t FullCnt = cnt_t'(NrSlots);

    slot_state_e            state_q [NrSlots];
    slot_state_e            state_d [NrSlots];
    tag_t                   head_q, head_d, tail_q, tail_d;
    cnt_t                   count_q, count_d, store_cnt_q, store_cnt_d;

    logic [TransIdBits-1:0] trans_id_q [NrSlots];
    logic [XLEN-1:0]        result_q   [NrSlots];
    logic                   error_q    [NrSlots];
    logic                   is_load_q  [NrSlots];
    logic                   is_store_q [NrSlots];

    logic full, alloc, pop, cpl_hit, req_is_store;

    // Full is masked in reset so the request handshake follows the core while the buffer clears.
    assign full             = !rst_i && (count_q == FullCnt);
    assign req_ready_o      = core_req_ready_i && !full;
    assign core_req_valid_o = req_valid_i && !full;
    assign core_insn_o      = req_insn_i;
    assign core_rs1_o       = req_rs1_i;
    assign core_rs2_o       = req_rs2_i;
    assign core_tag_o       = tail_q;

    assign alloc        = req_valid_i && req_ready_o;
    assign req_is_store = (req_insn_i[6:0] == StoreOpcode);
    assign cpl_hit      = core_resp_valid_i && (state_q[core_resp_tag_i] == SLOT_ISSUED);

`ifdef ACC_RESP_BYPASS_EN
    logic head_hit;
    assign head_hit = cpl_hit && (core_resp_tag_i == head_q);
`endif

    always_comb begin
        resp_valid_o    = 1'b0;
        resp_trans_id_o = '0;
        resp_result_o   = '0;
        resp_error_o    = 1'b0;
        if (!rst_i && state_q[head_q] == SLOT_DONE) begin
            resp_valid_o    = 1'b1;
            resp_trans_id_o = trans_id_q[head_q];
            resp_result_o   = result_q[head_q];
            resp_error_o    = error_q[head_q];
        end
`ifdef ACC_RESP_BYPASS_EN
        else if (!rst_i && head_hit) begin
            resp_valid_o    = 1'b1;
            resp_trans_id_o = trans_id_q[head_q];
            resp_result_o   = core_resp_result_i;
            resp_error_o    = core_resp_error_i;
        end
`endif
    end

    assign pop              = resp_valid_o && resp_ready_i;
    assign load_complete_o  = pop && is_load_q[head_q];
    assign store_complete_o = pop && is_store_q[head_q];
    assign store_pending_o  = !rst_i && (store_cnt_q != '0);
    assign idle_o           = rst_i || (count_q == '0);

    // NOTE: every always_comb output gets its default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        store_cnt_d = store_cnt_q;
        if (cpl_hit) begin
            state_d[core_resp_tag_i] = SLOT_DONE;
        end
        if (pop) begin
            state_d[head_q] = SLOT_FREE;
            head_d          = head_q + tag_t'(1);
        end
        if (alloc) begin
            state_d[tail_q] = SLOT_ISSUED;
            tail_d          = tail_q + tag_t'(1);
        end
        case ({alloc, pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
        case ({alloc && req_is_store, pop && is_store_q[head_q]})
            2'b10:   store_cnt_d = store_cnt_q + cnt_t'(1);
            2'b01:   store_cnt_d = store_cnt_q - cnt_t'(1);
            default: store_cnt_d = store_cnt_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NrSlots; i++) begin
                state_q[i] <= SLOT_FREE;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            store_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    // NOTE: payload memories are not reset; they are only observed through a non-FREE slot.
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            trans_id_q[tail_q] <= req_trans_id_i;
            is_load_q[tail_q]  <= (req_insn_i[6:0] == LoadOpcode);
            is_store_q[tail_q] <= req_is_store;
        end
        if (cpl_hit) begin
            result_q[core_resp_tag_i] <= core_resp_result_i;
            error_q[core_resp_tag_i]  <= core_resp_error_i;
        end
    end

    // Completions for slots that are not ISSUED are dropped; flag them in simulation.
    always_ff @(posedge clk_i) begin
        if (!rst_i && core_resp_valid_i) begin
            assert (state_q[core_resp_tag_i] == SLOT_ISSUED)
                else $warning("acc_resp_reorder: completion for non-issued slot %0d ignored",
                              core_resp_tag_i);
        end
    end

endmodule

// File: tb/tb_acc_resp_reorder.sv
// Self-checking bench for acc_resp_reorder: table-driven single transactions plus corner-case sequences.
module tb_acc_resp_reorder;

    localparam logic [6:0] LoadOp  = 7'b0000111;
    localparam logic [6:0] StoreOp = 7'b0100111;
    localparam logic [6:0] AluOp   = 7'b0110011;
`ifdef ACC_RESP_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i, req_valid_i, req_ready_o, core_req_valid_o, core_req_ready_i;
    logic [31:0] req_insn_i, core_insn_o;
    logic [63:0] req_rs1_i, req_rs2_i, core_rs1_o, core_rs2_o, core_resp_result_i, resp_result_o;
    logic [2:0]  req_trans_id_i, resp_trans_id_o;
    logic [1:0]  core_tag_o, core_resp_tag_i;
    logic        core_resp_valid_i, core_resp_error_i, resp_valid_o, resp_ready_i, resp_error_o;
    logic        load_complete_o, store_complete_o, store_pending_o, idle_o;

    always #5 clk_i = ~clk_i;

    acc_resp_reorder dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_insn_i(req_insn_i),
        .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_trans_id_i(req_trans_id_i),
        .core_req_valid_o(core_req_valid_o), .core_req_ready_i(core_req_ready_i),
        .core_insn_o(core_insn_o), .core_rs1_o(core_rs1_o), .core_rs2_o(core_rs2_o),
        .core_tag_o(core_tag_o), .core_resp_valid_i(core_resp_valid_i),
        .core_resp_tag_i(core_resp_tag_i), .core_resp_result_i(core_resp_result_i),
        .core_resp_error_i(core_resp_error_i), .resp_valid_o(resp_valid_o),
        .resp_ready_i(resp_ready_i), .resp_trans_id_o(resp_trans_id_o),
        .resp_result_o(resp_result_o), .resp_error_o(resp_error_o),
        .load_complete_o(load_complete_o), .store_complete_o(store_complete_o),
        .store_pending_o(store_pending_o), .idle_o(idle_o)
    );

    typedef struct {
        logic [2:0]  tid;
        logic [63:0] res;
        logic        err;
        logic        ld;
        logic        st;
    } exp_t;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  tid;
        logic [63:0] res;
        logic        err;
        logic        exp_ld;
        logic        exp_st;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb [$];
    int          pend [$];
    logic [1:0]  exp_tail = 2'd0;
    logic [63:0] tag_res [4];
    logic        tag_err [4];
    vec_t        vecs [6];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard monitor: every pop is compared against the oldest issued transaction.
    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (resp_valid_o === 1'b1 && resp_ready_i === 1'b1) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", 64'(resp_valid_o), 64'd0);
            end else begin
                e = sb.pop_front();
                check("resp_trans_id", 64'(resp_trans_id_o), 64'(e.tid));
                check("resp_result", resp_result_o, e.res);
                check("resp_error", 64'(resp_error_o), 64'(e.err));
                check("load_complete", 64'(load_complete_o), 64'(e.ld));
                check("store_complete", 64'(store_complete_o), 64'(e.st));
            end
        end else begin
            check("pulse_without_pop", 64'({load_complete_o, store_complete_o}), 64'd0);
        end
    end

    task automatic do_reset();
        rst_i             = 1'b1;
        req_valid_i       = 1'b0;
        core_resp_valid_i = 1'b0;
        resp_ready_i      = 1'b0;
        tick();
        rst_i = 1'b0;
        sb.delete();
        pend.delete();
        exp_tail = 2'd0;
    endtask

    task automatic issue(input logic [6:0] opc, input logic [2:0] tid, input logic [63:0] res,
                         input logic err, input logic ld, input logic st);
        logic [31:0] insn;
        logic [63:0] a, b;
        insn      = $urandom;
        insn[6:0] = opc;
        a         = {$urandom, $urandom};
        b         = {$urandom, $urandom};
        req_valid_i      = 1'b1;
        req_insn_i       = insn;
        req_rs1_i        = a;
        req_rs2_i        = b;
        req_trans_id_i   = tid;
        core_req_ready_i = 1'b1;
        @(negedge clk_i);
        check("req_ready", 64'(req_ready_o), 64'd1);
        check("core_req_valid", 64'(core_req_valid_o), 64'd1);
        check("core_tag", 64'(core_tag_o), 64'(exp_tail));
        check("core_insn", 64'(core_insn_o), 64'(insn));
        check("core_rs1", core_rs1_o, a);
        check("core_rs2", core_rs2_o, b);
        sb.push_back('{tid, res, err, ld, st});
        pend.push_back(int'(exp_tail));
        tag_res[exp_tail] = res;
        tag_err[exp_tail] = err;
        exp_tail = exp_tail + 2'd1;
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic drive_cpl(input int tag);
        core_resp_valid_i  = 1'b1;
        core_resp_tag_i    = 2'(tag);
        core_resp_result_i = tag_res[tag];
        core_resp_error_i  = tag_err[tag];
        for (int i = 0; i < pend.size(); i++) begin
            if (pend[i] == tag) begin
                pend.delete(i);
                break;
            end
        end
    endtask

    task automatic complete(input int tag);
        drive_cpl(tag);
        tick();
        core_resp_valid_i = 1'b0;
    endtask

    task automatic drain();
        int budget;
        resp_ready_i = 1'b1;
        while (pend.size() > 0) complete(pend.pop_back());
        budget = 0;
        while (sb.size() > 0 && budget < 20) begin
            tick();
            budget++;
        end
        check("drain_left", 64'(sb.size()), 64'd0);
        @(negedge clk_i);
        check("drain_idle", 64'(idle_o), 64'd1);
        check("drain_store_pending", 64'(store_pending_o), 64'd0);
        tick();
        resp_ready_i = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int          tag;
        int          ooo_order [3];
        logic [5:0]  exp_v;

        vecs[0] = '{LoadOp,      3'd5, 64'hDEAD,                1'b0, 1'b1, 1'b0};
        vecs[1] = '{StoreOp,     3'd2, 64'h1234_5678,           1'b0, 1'b0, 1'b1};
        vecs[2] = '{AluOp,       3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{7'b0000011,  3'd0, 64'hA5A5,                1'b0, 1'b0, 1'b0};
        vecs[4] = '{7'b0100011,  3'd3, 64'h5A,                  1'b1, 1'b0, 1'b0};
        vecs[5] = '{StoreOp,     3'd6, 64'h0,                   1'b1, 1'b0, 1'b1};

        // Reset state: handshake follows the core, response side quiet.
        rst_i = 1'b1; req_valid_i = 1'b1; core_req_ready_i = 1'b1; req_insn_i = '0;
        req_rs1_i = '0; req_rs2_i = '0; req_trans_id_i = '0; core_resp_valid_i = 1'b0;
        core_resp_tag_i = '0; core_resp_result_i = '0; core_resp_error_i = 1'b0; resp_ready_i = 1'b0;
        tick();
        @(negedge clk_i);
        check("rst_req_ready", 64'(req_ready_o), 64'd1);
        check("rst_core_req_valid", 64'(core_req_valid_o), 64'd1);
        check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        check("rst_idle", 64'(idle_o), 64'd1);
        check("rst_store_pending", 64'(store_pending_o), 64'd0);
        check("rst_resp_fields", {resp_result_o[60:0], resp_trans_id_o}, 64'd0);
        tick();
        rst_i = 1'b0; req_valid_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_idle", 64'(idle_o), 64'd1);
        check("post_rst_resp_error", 64'(resp_error_o), 64'd0);
        tick();

        // Table: one transaction at a time, complete one cycle after issue.
        for (int i = 0; i < 6; i++) begin
            resp_ready_i = 1'b1;
            issue(vecs[i].opc, vecs[i].tid, vecs[i].res, vecs[i].err, vecs[i].exp_ld, vecs[i].exp_st);
            @(negedge clk_i);
            check("vec_store_pending", 64'(store_pending_o), 64'(vecs[i].exp_st));
            check("vec_busy", 64'(idle_o), 64'd0);
            tick();
            tag = pend[0];
            drive_cpl(tag);
            @(negedge clk_i);
            check("vec_valid_cpl_cycle", 64'(resp_valid_o), 64'(Bypass));
            tick();
            core_resp_valid_i = 1'b0;
            @(negedge clk_i);
            check("vec_valid_next_cycle", 64'(resp_valid_o), 64'(!Bypass));
            tick();
            @(negedge clk_i);
            check("vec_idle_after", 64'(idle_o), 64'd1);
            check("vec_valid_after", 64'(resp_valid_o), 64'd0);
            tick();
        end

        // Out-of-order completion 2,0,1 must still return 1,2,3 one per cycle.
        do_reset();
        resp_ready_i = 1'b1;
        issue(AluOp, 3'd1, 64'hA001, 1'b0, 1'b0, 1'b0);
        issue(AluOp, 3'd2, 64'hA002, 1'b1, 1'b0, 1'b0);
        issue(AluOp, 3'd3, 64'hA003, 1'b0, 1'b0, 1'b0);
        ooo_order = '{2, 0, 1};
        exp_v     = Bypass ? 6'b001110 : 6'b011100;
        for (int k = 0; k < 6; k++) begin
            if (k < 3) drive_cpl(ooo_order[k]);
            else core_resp_valid_i = 1'b0;
            @(negedge clk_i);
            check("ooo_valid", 64'(resp_valid_o), 64'(exp_v[k]));
            tick();
        end
        core_resp_valid_i = 1'b0;
        check("ooo_all_returned", 64'(sb.size()), 64'd0);

        // Full: no acceptance at NrSlots, no same-cycle bypass on pop, wrap to tag 0.
        do_reset();
        req_valid_i = 1'b1; core_req_ready_i = 1'b0;
        @(negedge clk_i);
        check("core_bp_req_ready", 64'(req_ready_o), 64'd0);
        check("core_bp_core_req_valid", 64'(core_req_valid_o), 64'd1);
        tick();
        req_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) issue(AluOp, 3'(i), 64'h100 + 64'(i), 1'b0, 1'b0, 1'b0);
        req_valid_i = 1'b1;
        @(negedge clk_i);
        check("full_req_ready", 64'(req_ready_o), 64'd0);
        check("full_core_req_valid", 64'(core_req_valid_o), 64'd0);
        tick();
        req_valid_i = 1'b0;
        complete(0);
        resp_ready_i = 1'b1; req_valid_i = 1'b1;
        @(negedge clk_i);
        check("full_pop_valid", 64'(resp_valid_o), 64'd1);
        check("full_pop_req_ready", 64'(req_ready_o), 64'd0);
        tick();
        req_valid_i = 1'b0; resp_ready_i = 1'b0;
        issue(AluOp, 3'd4, 64'h104, 1'b1, 1'b0, 1'b0);
        drain();

        // Stores: pending stays up until the last store retires.
        do_reset();
        issue(StoreOp, 3'd1, 64'hA1, 1'b0, 1'b0, 1'b1);
        issue(StoreOp, 3'd2, 64'hA2, 1'b0, 1'b0, 1'b1);
        @(negedge clk_i);
        check("st_pending_two", 64'(store_pending_o), 64'd1);
        tick();
        complete(0);
        complete(1);
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        check("st_cpl_first", 64'(store_complete_o), 64'd1);
        tick();
        resp_ready_i = 1'b0;
        @(negedge clk_i);
        check("st_pending_one", 64'(store_pending_o), 64'd1);
        check("st_cpl_gap", 64'(store_complete_o), 64'd0);
        tick();
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        check("st_cpl_second", 64'(store_complete_o), 64'd1);
        tick();
        resp_ready_i = 1'b0;
        @(negedge clk_i);
        check("st_pending_none", 64'(store_pending_o), 64'd0);
        check("st_idle", 64'(idle_o), 64'd1);
        tick();

        // Backpressure: response held stable until resp_ready_i rises.
        do_reset();
        issue(LoadOp, 3'd6, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b1, 1'b0);
        complete(0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check("bp_valid", 64'(resp_valid_o), 64'd1);
            check("bp_trans_id", 64'(resp_trans_id_o), 64'd6);
            check("bp_result", resp_result_o, 64'h0123_4567_89AB_CDEF);
            check("bp_error", 64'(resp_error_o), 64'd1);
            tick();
        end
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_pop_load_complete", 64'(load_complete_o), 64'd1);
        tick();
        resp_ready_i = 1'b0;
        @(negedge clk_i);
        check("bp_after_valid", 64'(resp_valid_o), 64'd0);
        check("bp_after_idle", 64'(idle_o), 64'd1);
        tick();

        // Reset mid-operation discards outstanding work and stale completions.
        do_reset();
        issue(LoadOp, 3'd1, 64'h11, 1'b0, 1'b1, 1'b0);
        issue(StoreOp, 3'd2, 64'h22, 1'b0, 1'b0, 1'b1);
        @(negedge clk_i);
        check("rm_pending", 64'(store_pending_o), 64'd1);
        check("rm_busy", 64'(idle_o), 64'd0);
        tick();
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rm_in_rst_idle", 64'(idle_o), 64'd1);
        check("rm_in_rst_pending", 64'(store_pending_o), 64'd0);
        tick();
        rst_i = 1'b0;
        sb.delete(); pend.delete(); exp_tail = 2'd0;
        @(negedge clk_i);
        check("rm_idle", 64'(idle_o), 64'd1);
        check("rm_pending_clear", 64'(store_pending_o), 64'd0);
        tick();
        resp_ready_i = 1'b1;
        drive_cpl(1);
        @(negedge clk_i);
        check("rm_late_cpl_valid", 64'(resp_valid_o), 64'd0);
        tick();
        core_resp_valid_i = 1'b0;
        @(negedge clk_i);
        check("rm_late_next_valid", 64'(resp_valid_o), 64'd0);
        check("rm_late_idle", 64'(idle_o), 64'd1);
        tick();
        issue(LoadOp, 3'd3, 64'h33, 1'b0, 1'b1, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
